n_channel_mixer: RTL
====================

// Module: n_channel_mixer
// PURPOSE
//  Time-multiplexed N-voice mixer with per-channel gain, channel enables, saturation and status flags.
//  Successor to the fixed two-input mixer; sits between the instrument_* voices and the audio output.
//  On each sample_strobe it snapshots all voice samples and gains, then MACs one channel per clock.
//  It presents one saturated mixed sample with a one-cycle dout_valid pulse.
// PARAMETERS
//  NUM_CH     4   number of voice channels (>=1)
//  DATA_W     16  sample width, signed two's complement (in and out)
//  GAIN_W     8   per-channel gain width, unsigned
//  GAIN_FRAC  7   gain fractional bits; gain==1<<GAIN_FRAC is unity (128)
//  ACC_W      DATA_W+GAIN_W+$clog2(NUM_CH)+1   accumulator width (derived, do not override)
// PORTS
//  clk            in   1              system clock
//  rst_n          in   1              synchronous active-low reset
//  din            in   NUM_CH*DATA_W  flat samples; ch i = din[i*DATA_W +: DATA_W]
//  gain           in   NUM_CH*GAIN_W  flat gains; ch i = gain[i*GAIN_W +: GAIN_W]
//  ch_enable      in   NUM_CH         1 = channel contributes; 0 = muted
//  sample_strobe  in   1              start a mix frame (single-cycle pulse expected)
//  clear_flags    in   1              clear sticky overrun/clip
//  dout           out  DATA_W         mixed sample, signed, held between frames
//  dout_valid     out  1              one-cycle pulse when dout updates
//  busy           out  1              high while in ACCUM
//  overrun        out  1              sticky: strobe dropped
//  clip           out  1              sticky: a frame saturated
// BEHAVIOUR
//  Reset (rst_n low at posedge clk): state=IDLE; dout, dout_valid, overrun, clip=0; idx, acc, shadow regs=0.
//    Reset mid-frame aborts the frame and produces no dout_valid.
//  FSM states: IDLE, ACCUM, OUTPUT. busy = (state==ACCUM).
//  Strobe acceptance: in IDLE or OUTPUT, sample_strobe=1 at edge T latches din/gain/ch_enable into shadow regs.
//    It also clears acc, sets idx=0 and moves to ACCUM. Input changes after edge T do not affect that frame.
//  ACCUM: each edge, acc += ch_en[idx] ? $signed(din[idx]) * $signed({1'b0,gain[idx]}) : 0; idx++.
//    The add at idx==NUM_CH-1 is the last one; that edge moves to OUTPUT.
//  OUTPUT (one cycle): r = acc >>> GAIN_FRAC (arithmetic shift, floor).
//    Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; dout<=sat(r) and dout_valid<=1 on the edge leaving OUTPUT.
//    The next state is ACCUM if a strobe is present in that cycle, else IDLE.
//  Timing: strobe sampled at edge T -> dout/dout_valid registered at edge T+NUM_CH+1.
//    Max frame rate is one per NUM_CH+1 cycles (back-to-back via OUTPUT).
//  dout_valid is high for exactly one cycle per accepted frame, otherwise 0.
//  Overrun: sample_strobe in ACCUM is ignored; the current frame completes unchanged; overrun<=1.
//  Clip: clip<=1 on the OUTPUT edge when sat(r)!=r.
//  clear_flags clears overrun and clip. If a set event occurs in the same cycle, set wins (flag=1).
//  All channels disabled or all gains 0: dout=0 with normal dout_valid.
//  Width rules: products are DATA_W+GAIN_W+1 signed; acc ACC_W signed, never overflows for any inputs.
// TESTING (NUM_CH=4, DATA_W=16, GAIN_W=8, GAIN_FRAC=7)
//  1 Unity: gains=128, din={0,-500,2000,1000} (ch3..0), en=4'hF, strobe at edge T
//    -> dout=2500, dout_valid only at T+5, busy high edges T..T+3 states.
//  2 Scaling/floor: all gains 64, din=100 each -> 200.
//    Then ch0 only (en=4'b0001), din0=-3, g0=64 -> dout=-2.
//  3 Saturation: all din=30000, gains=255 -> dout=32767, clip=1.
//    All din=-32768, gains=255 -> dout=-32768; clear_flags -> clip=0.
//  4 Overrun: second strobe 2 cycles after first, with different din
//    -> single dout_valid with first-frame result, overrun=1. clear_flags+strobe drop same cycle -> overrun stays 1.
//  5 Back-to-back: strobe every 5 cycles, en=4'b0101, din changed after each strobe
//    -> every frame valid, only ch0+ch2 summed, no overrun.
//  6 Reset mid-frame: rst_n=0 two cycles after strobe, for 1 cycle
//    -> no dout_valid, dout=0, flags=0; the next strobe mixes normally.

Source files
------------

// File: rtl/n_channel_mixer.sv
// Time-multiplexed N-voice mixer: snapshots all voices on a strobe, then
// multiply-accumulates one channel per clock and emits a saturated sample.
module n_channel_mixer #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   din,
  input  logic [NUM_CH*GAIN_W-1:0]   gain,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic                       sample_strobe,
  input  logic                       clear_flags,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic                       busy,
  output logic                       overrun,
  output logic                       clip
);

  localparam int ACC_W  = DATA_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  // Output range expressed at accumulator width so the comparison is exact
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] sh_din  [NUM_CH];
  logic        [GAIN_W-1:0] sh_gain [NUM_CH];
  logic        [NUM_CH-1:0] sh_en;
  logic        [IDX_W-1:0]  idx;
  logic signed [ACC_W-1:0]  acc;

  logic                     accept;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  shifted;
  logic        [DATA_W-1:0] sat_val;
  logic                     clip_now;

  assign accept = sample_strobe && (state != ACCUM);
  assign busy   = (state == ACCUM);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_strobe) state_next = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_next = OUTPUT;
      OUTPUT:  state_next = sample_strobe ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The gain is zero-extended so an unsigned gain multiplies as a positive value
  always_comb begin
    prod     = '0;
    if (sh_en[idx])
      prod = PROD_W'(sh_din[idx]) * PROD_W'($signed({1'b0, sh_gain[idx]}));
    shifted  = acc >>> GAIN_FRAC;
    clip_now = (shifted > SAT_MAX) || (shifted < SAT_MIN);
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_din[i]  <= '0;
        sh_gain[i] <= '0;
      end
      sh_en      <= '0;
      idx        <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      clip       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NUM_CH; i++) begin
          sh_din[i]  <= din[i*DATA_W +: DATA_W];
          sh_gain[i] <= gain[i*GAIN_W +: GAIN_W];
        end
        sh_en <= ch_enable;
        idx   <= '0;
        acc   <= '0;
      end else if (state == ACCUM) begin
        acc <= acc + ACC_W'(prod);
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      // Result of the finishing frame is published even when a new frame starts on this edge
      if (state == OUTPUT) begin
        dout       <= sat_val;
        dout_valid <= 1'b1;
      end
      overrun <= (sample_strobe && state == ACCUM) || (overrun && !clear_flags);
      clip    <= (state == OUTPUT && clip_now) || (clip && !clear_flags);
    end
  end

endmodule
